// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: picks the lit 3x3 cell from an LFSR, times each
// round, scores keypad presses and reports game status to the renderer.
module mole_game_ctrl #(
    parameter int         SHOW_CYCLES  = 25_000_000,
    parameter int         FLASH_CYCLES = 12_500_000,
    parameter int         GAP_CYCLES   = 5_000_000,
    parameter int         ROUNDS       = 20,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    output logic       o_in_game,
    output logic       o_hit,
    output logic [3:0] o_position,
    output logic [7:0] o_score,
    output logic [7:0] o_misses,
    output logic       o_game_over
);

    localparam int MAX_SF = (SHOW_CYCLES > FLASH_CYCLES) ? SHOW_CYCLES : FLASH_CYCLES;
    localparam int MAX_C  = (MAX_SF > GAP_CYCLES) ? MAX_SF : GAP_CYCLES;
    localparam int TW     = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_SHOW  = 3'd2,
        S_FLASH = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [TW-1:0] r_timer;
    logic [7:0]  r_round;
    logic [3:0]  r_prev_pos;
    logic [7:0]  r_lfsr;

    logic        w_lfsr_fb;
    logic [3:0]  w_cand;
    logic        w_cand_ok;
    logic        w_key_match;
    logic        w_show_end;
    logic        w_flash_end;
    logic        w_gap_end;
    logic        w_last_round;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cand       = r_lfsr[3:0];
    assign w_cand_ok    = (w_cand >= 4'd1) && (w_cand <= 4'd9) && (w_cand != r_prev_pos);
    // position is never 0 while in SHOW, so key code 0 can never match
    assign w_key_match  = i_key_valid && (i_key_code == o_position);
    assign w_show_end   = (r_timer == TW'(SHOW_CYCLES - 1));
    assign w_flash_end  = (r_timer == TW'(FLASH_CYCLES - 1));
    assign w_gap_end    = (r_timer == TW'(GAP_CYCLES - 1));
    assign w_last_round = ((r_round + 8'd1) == 8'(ROUNDS));

    // Free-running cell picker, shifts every cycle including IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Game FSM with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_round     <= 8'd0;
            r_prev_pos  <= 4'd0;
            o_in_game   <= 1'b0;
            o_hit       <= 1'b0;
            o_position  <= 4'd0;
            o_score     <= 8'd0;
            o_misses    <= 8'd0;
            o_game_over <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= S_SPAWN;
                        r_round     <= 8'd0;
                        o_score     <= 8'd0;
                        o_misses    <= 8'd0;
                        o_in_game   <= 1'b1;
                        o_game_over <= 1'b0;
                    end
                end
                S_SPAWN: begin
                    if (w_cand_ok) begin
                        o_position <= w_cand;
                        r_prev_pos <= w_cand;
                        r_timer    <= '0;
                        r_state    <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    // a matching key on the timeout cycle counts as a hit
                    if (w_key_match) begin
                        o_score <= sat_inc(o_score);
                        o_hit   <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_FLASH;
                    end else if (w_show_end) begin
                        o_misses   <= sat_inc(o_misses);
                        o_position <= 4'd0;
                        r_timer    <= '0;
                        r_state    <= S_GAP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                        if (i_key_valid) begin
                            o_misses <= sat_inc(o_misses);
                        end
                    end
                end
                S_FLASH: begin
                    if (w_flash_end) begin
                        o_hit      <= 1'b0;
                        o_position <= 4'd0;
                        r_timer    <= '0;
                        r_state    <= S_GAP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_round <= r_round + 8'd1;
                        r_timer <= '0;
                        if (w_last_round) begin
                            r_state     <= S_DONE;
                            o_in_game   <= 1'b0;
                            o_game_over <= 1'b1;
                        end else begin
                            r_state <= S_SPAWN;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed scenarios plus random keypad traffic, every
// cycle compared against a phase/countdown reference model of the game rules.
module tb_mole_game_ctrl;

    localparam int         S    = 8;
    localparam int         F    = 4;
    localparam int         G    = 2;
    localparam int         R    = 3;
    localparam logic [7:0] SEED = 8'hA5;

    localparam int P_IDLE = 0, P_SPAWN = 1, P_SHOW = 2, P_FLASH = 3, P_GAP = 4, P_DONE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       in_game, hit, game_over;
    logic [3:0] position;
    logic [7:0] score, misses;

    int checks = 0;
    int errors = 0;

    int         m_phase = P_IDLE;
    int         m_left  = 0;
    int         m_round = 0;
    int         m_score = 0;
    int         m_miss  = 0;
    logic [3:0] m_pos   = 4'd0;
    logic [3:0] m_prev  = 4'd0;
    logic [7:0] m_lfsr  = SEED;

    mole_game_ctrl #(
        .SHOW_CYCLES (S),
        .FLASH_CYCLES(F),
        .GAP_CYCLES  (G),
        .ROUNDS      (R),
        .LFSR_SEED   (SEED)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_key_valid(key_valid),
        .i_key_code (key_code),
        .o_in_game  (in_game),
        .o_hit      (hit),
        .o_position (position),
        .o_score    (score),
        .o_misses   (misses),
        .o_game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Game rules, one clock edge at a time; m_left counts cycles still to spend in a phase
    task automatic model_step(input logic r, input logic st, input logic kv, input logic [3:0] kc);
        logic [7:0] cur;
        cur    = m_lfsr;
        m_lfsr = r ? SEED : ((cur << 1) | {7'd0, ^(cur & 8'hB8)});
        if (r) begin
            m_phase = P_IDLE; m_left = 0; m_round = 0; m_score = 0; m_miss = 0;
            m_pos = 4'd0; m_prev = 4'd0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: begin
                    if (st) begin
                        m_phase = P_SPAWN; m_score = 0; m_miss = 0; m_round = 0;
                    end
                end
                P_SPAWN: begin
                    if (cur[3:0] >= 4'd1 && cur[3:0] <= 4'd9 && cur[3:0] != m_prev) begin
                        m_pos = cur[3:0]; m_prev = cur[3:0]; m_phase = P_SHOW; m_left = S;
                    end
                end
                P_SHOW: begin
                    if (kv && kc == m_pos) begin
                        m_score = sat(m_score); m_phase = P_FLASH; m_left = F;
                    end else if (m_left == 1) begin
                        m_miss = sat(m_miss); m_pos = 4'd0; m_phase = P_GAP; m_left = G;
                    end else begin
                        m_left--;
                        if (kv) m_miss = sat(m_miss);
                    end
                end
                P_FLASH: begin
                    if (m_left == 1) begin
                        m_pos = 4'd0; m_phase = P_GAP; m_left = G;
                    end else m_left--;
                end
                P_GAP: begin
                    if (m_left == 1) begin
                        m_round++;
                        m_phase = (m_round == R) ? P_DONE : P_SPAWN;
                    end else m_left--;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic cmp_all();
        chk("in_game",   in_game,   (m_phase >= P_SPAWN && m_phase <= P_GAP) ? 1 : 0);
        chk("hit",       hit,       (m_phase == P_FLASH) ? 1 : 0);
        chk("position",  position,  m_pos);
        chk("score",     score,     m_score);
        chk("misses",    misses,    m_miss);
        chk("game_over", game_over, (m_phase == P_DONE) ? 1 : 0);
    endtask

    // One clock: inputs held for the cycle, model stepped at the edge, outputs compared after
    task automatic cyc(input logic st, input logic kv, input logic [3:0] kc);
        start = st; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_step(rst, st, kv, kc);
        #1;
        cmp_all();
        start = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    endtask

    task automatic run_until(input int phase, input int budget, input string tag);
        int n;
        n = 0;
        while (m_phase != phase && n < budget) begin
            cyc(1'b0, 1'b0, 4'd0);
            n++;
        end
        chk({tag, "_reached"}, (m_phase == phase) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int z;
        logic [3:0] prev_seen;
        logic [3:0] wrong;
        logic kv;
        logic [3:0] kc;

        // reset with start held high: must be ignored
        rst = 1'b1;
        cyc(1'b1, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 4'd0);
        chk("reset_position", position, 0);
        chk("reset_in_game", in_game, 0);
        rst = 1'b0;

        // reset in the middle of SHOW
        cyc(1'b1, 1'b0, 4'd0);
        run_until(P_SHOW, 40, "pre_rst_show");
        cyc(1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 4'd0);
        chk("midrst_idle_pos", position, 0);
        chk("midrst_in_game", in_game, 0);
        cyc(1'b1, 1'b0, 4'd0);
        rst = 1'b0;

        // press the lit cell three cycles into SHOW
        cyc(1'b1, 1'b0, 4'd0);
        run_until(P_SHOW, 40, "a_show");
        cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 4'd0);
        prev_seen = position;
        cyc(1'b0, 1'b1, m_pos);
        chk("a_score", score, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (hit !== 1'b1) break;
            n++;
            cyc(1'b0, 1'b0, 4'd0);
        end
        chk("a_hit_len", n, F);
        z = 0;
        for (int i = 0; i < 40; i++) begin
            if (position !== 4'd0) break;
            z++;
            cyc(1'b0, 1'b0, 4'd0);
        end
        chk("a_gap_len_ge", (z >= G) ? 1 : 0, 1);
        chk("a_next_in_range", (position >= 4'd1 && position <= 4'd9) ? 1 : 0, 1);
        chk("a_next_differs", (position != prev_seen) ? 1 : 0, 1);
        run_until(P_DONE, 200, "a_done");

        // start in DONE then no keys: every SHOW times out after S cycles
        cyc(1'b1, 1'b0, 4'd0);
        chk("b_restart_score", score, 0);
        chk("b_restart_misses", misses, 0);
        chk("b_restart_over", game_over, 0);
        chk("b_restart_in_game", in_game, 1);
        for (int rd = 0; rd < R; rd++) begin
            run_until(P_SHOW, 40, "b_show");
            n = 0;
            for (int i = 0; i < 20; i++) begin
                if (position === 4'd0) break;
                n++;
                cyc(1'b0, 1'b0, 4'd0);
            end
            chk("b_show_len", n, S);
        end
        run_until(P_DONE, 40, "b_done");
        chk("b_misses", misses, R);
        chk("b_score", score, 0);
        chk("b_game_over", game_over, 1);

        // wrong key then right key, idle key and start in GAP, timeout-cycle hit
        cyc(1'b1, 1'b0, 4'd0);
        run_until(P_SHOW, 40, "c_show");
        wrong = (m_pos == 4'd9) ? 4'd1 : m_pos + 4'd1;
        cyc(1'b0, 1'b1, wrong);
        cyc(1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, m_pos);
        chk("c_misses", misses, 1);
        chk("c_score", score, 1);
        run_until(P_GAP, 40, "c_gap");
        cyc(1'b1, 1'b1, 4'd5);
        chk("c_gap_key_score", score, 1);
        chk("c_gap_key_misses", misses, 1);
        chk("c_midgame_start", in_game, 1);
        run_until(P_SHOW, 40, "c_show2");
        n = 0;
        while (m_left != 1 && n < 20) begin
            cyc(1'b0, 1'b0, 4'd0);
            n++;
        end
        chk("c_wait_cycles", n, S - 1);
        cyc(1'b0, 1'b1, m_pos);
        chk("c_timeout_hit", hit, 1);
        chk("c_timeout_score", score, 2);
        chk("c_timeout_misses", misses, 1);
        run_until(P_DONE, 200, "c_done");

        // random keypad traffic over several games
        for (int g = 0; g < 4; g++) begin
            cyc(1'b1, 1'b0, 4'd0);
            n = 0;
            while (m_phase != P_DONE && n < 2000) begin
                kv = ($urandom_range(0, 3) == 0);
                kc = ($urandom_range(0, 1) == 0) ? m_pos : 4'($urandom_range(0, 15));
                if (m_phase == P_SHOW && m_left == 1 && kc != m_pos) kv = 1'b0;
                cyc(($urandom_range(0, 15) == 0), kv, kc);
                n++;
            end
            chk("rand_done", (m_phase == P_DONE) ? 1 : 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
